io_console_ctrl: RTL and testbench

IO_CONSOLE_CTRL -- requirements
Module: io_console_ctrl

---
 rtl/io_console_ctrl.sv | 95 +++++++++
 tb/tb_io_console_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_console_ctrl.sv
// Memory-mapped console: CPU writes to ADDR_STDOUT are queued in a small FIFO and streamed out
// on a valid/ready port; a write to ADDR_HALT drains the FIFO and then raises o_halt.
module io_console_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter logic [23:0] ADDR_STDOUT = 24'hFFFFFE,
    parameter logic [23:0] ADDR_HALT   = 24'hFFFFFF
) (
    input  logic                       i_clk,
    input  logic                       i_rstb,
    input  logic                       i_clk_en,
    input  logic [23:0]                i_daddr,
    input  logic [31:0]                i_dout,
    input  logic                       i_wr,
    output logic                       o_stall,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic                       o_halt,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [15:0]                o_char_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   head_q, tail_q;
    logic [LW-1:0]   level_q;
    logic [15:0]     count_q;
    logic [7:0]      mem_q [DEPTH];

    logic stdout_wr, halt_wr, full, push, pop;

    assign stdout_wr = i_wr & (i_daddr == ADDR_STDOUT);
    assign halt_wr   = i_wr & (i_daddr == ADDR_HALT);
    assign full      = (level_q == LW'(DEPTH));

    // A full FIFO stalls even if a pop frees a slot this cycle.
    always_comb begin
        o_stall = 1'b0;
        unique case (state_q)
            StRun:   o_stall = stdout_wr & full;
            StDrain: o_stall = stdout_wr | halt_wr;
            default: o_stall = 1'b0;
        endcase
    end

    assign o_tx_valid = (level_q != '0);
    assign o_tx_data  = o_tx_valid ? mem_q[head_q] : 8'h00;
    assign push       = stdout_wr & ~o_stall & i_clk_en & (state_q == StRun);
    assign pop        = o_tx_valid & i_tx_ready & i_clk_en;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (halt_wr) state_d = StDrain;
            StDrain: if ((level_q == '0) || ((level_q == LW'(1)) && pop)) state_d = StHalted;
            default: state_d = StHalted;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q <= StRun;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            count_q <= '0;
        end else if (i_clk_en) begin
            state_q <= state_d;
            if (push) tail_q <= tail_q + AW'(1);
            if (pop) begin
                head_q  <= head_q + AW'(1);
                count_q <= count_q + 16'd1;
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: o_tx_data is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[tail_q] <= i_dout[7:0];
    end

    assign o_halt       = (state_q == StHalted);
    assign o_level      = level_q;
    assign o_char_count = count_q;

endmodule

// File: tb/tb_io_console_ctrl.sv
// Bench for io_console_ctrl: directed scenarios plus random traffic, checked by a
// queue-based reference model and a scoreboard monitor sampling on the falling edge.
`timescale 1ns/1ps
module tb_io_console_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam logic [23:0] STDOUT = 24'hFFFFFE;
    localparam logic [23:0] HALT   = 24'hFFFFFF;

    logic          clk = 1'b0, rstb = 1'b0, clk_en = 1'b0, wr = 1'b0, tx_ready = 1'b0;
    logic [23:0]   daddr = '0;
    logic [31:0]   dout = '0;
    logic          stall, tx_valid, halt;
    logic [7:0]    tx_data;
    logic [LW-1:0] level;
    logic [15:0]   char_count;

    io_console_ctrl #(.DEPTH(DEPTH), .ADDR_STDOUT(STDOUT), .ADDR_HALT(HALT)) dut (
        .i_clk(clk), .i_rstb(rstb), .i_clk_en(clk_en), .i_daddr(daddr), .i_dout(dout),
        .i_wr(wr), .o_stall(stall), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
        .i_tx_ready(tx_ready), .o_halt(halt), .o_level(level), .o_char_count(char_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: console modes 0=run, 1=drain, 2=halted; FIFO as a byte queue.
    byte unsigned m_q[$];
    byte unsigned exp_q[$];
    int           m_mode = 0;
    logic [15:0]  m_count = 16'd0;

    function automatic bit m_stall();
        if (!wr) return 1'b0;
        if (m_mode == 0) return (daddr == STDOUT) && (m_q.size() == DEPTH);
        if (m_mode == 1) return (daddr == STDOUT) || (daddr == HALT);
        return 1'b0;
    endfunction

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_q.delete();
            m_mode  = 0;
            m_count = 16'd0;
        end else if (clk_en) begin
            bit do_pop, do_push;
            do_pop  = (m_q.size() != 0) && tx_ready;
            do_push = wr && (daddr == STDOUT) && !m_stall() && (m_mode == 0);
            if (m_mode == 1 && (m_q.size() == 0 || (m_q.size() == 1 && do_pop))) m_mode = 2;
            else if (m_mode == 0 && wr && daddr == HALT) m_mode = 1;
            if (do_pop) begin
                void'(m_q.pop_front());
                m_count = m_count + 16'd1;
            end
            if (do_push) begin
                m_q.push_back(dout[7:0]);
                exp_q.push_back(dout[7:0]);
            end
        end
    end

    // Monitor: compares every output each cycle and pops the scoreboard on each transfer.
    always @(negedge clk) begin
        if (!rstb) begin
            exp_q.delete();
            check("rst_valid", int'(tx_valid), 0);
            check("rst_data", int'(tx_data), 0);
            check("rst_level", int'(level), 0);
            check("rst_halt", int'(halt), 0);
            check("rst_count", int'(char_count), 0);
        end else begin
            check("level", int'(level), m_q.size());
            check("valid", int'(tx_valid), int'(m_q.size() != 0));
            check("count", int'(char_count), int'(m_count));
            check("halt", int'(halt), int'(m_mode == 2));
            check("stall", int'(stall), int'(m_stall()));
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", int'(tx_data), -1);
                end else if (tx_ready && clk_en) begin
                    check("tx_data", int'(tx_data), int'(exp_q.pop_front()));
                end else begin
                    check("tx_data_hold", int'(tx_data), int'(exp_q[0]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0; wr = 1'b0; clk_en = 1'b1; tx_ready = 1'b0; daddr = '0; dout = '0;
        repeat (3) step();
        rstb = 1'b1;
    endtask

    task automatic write(input logic [23:0] a, input logic [31:0] d);
        wr = 1'b1; daddr = a; dout = d;
        step();
        wr = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single character
        wr = 1'b1; daddr = STDOUT; dout = 32'hDEAD_BE41; tx_ready = 1'b1;
        step();
        wr = 1'b0;
        #2;
        check("single_valid", int'(tx_valid), 1);
        check("single_data", int'(tx_data), 8'h41);
        step();
        #2;
        check("single_count", int'(char_count), 1);
        check("single_level", int'(level), 0);

        // Fill to full, stall on the fifth write, then drain in order
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1; daddr = STDOUT; dout = 32'h30 + i;
            if (i == 4) begin
                #2;
                check("full_stall", int'(stall), 1);
                check("full_level", int'(level), 4);
                tx_ready = 1'b1;
            end
            step();
        end
        step();
        wr = 1'b0;
        repeat (6) step();
        check("full_drained", int'(level), 0);

        // Simultaneous push and pop at level 2
        tx_ready = 1'b0;
        write(STDOUT, 32'h50);
        write(STDOUT, 32'h51);
        wr = 1'b1; daddr = STDOUT; dout = 32'h52; tx_ready = 1'b1;
        step();
        wr = 1'b0;
        #2;
        check("pushpop_level", int'(level), 2);
        tx_ready = 1'b0;
        step();
        tx_ready = 1'b1;
        repeat (3) step();

        // Halt: three queued, drain, halt right after the third pop
        tx_ready = 1'b0;
        write(STDOUT, 32'h61);
        write(STDOUT, 32'h62);
        write(STDOUT, 32'h63);
        write(HALT, $urandom);
        wr = 1'b1; daddr = STDOUT; dout = 32'h64;
        #2;
        check("drain_stall", int'(stall), 1);
        step();
        wr = 1'b0; tx_ready = 1'b1;
        repeat (2) step();
        #2;
        check("drain_not_halted", int'(halt), 0);
        step();
        #2;
        check("halted", int'(halt), 1);
        check("halted_valid", int'(tx_valid), 0);
        wr = 1'b1; daddr = STDOUT; dout = 32'h65;
        #1;
        check("halted_no_stall", int'(stall), 0);
        step();
        wr = 1'b0;
        #2;
        check("halted_ignore", int'(level), 0);

        // Clock enable low holds everything
        do_reset();
        tx_ready = 1'b0;
        write(STDOUT, 32'h71);
        write(STDOUT, 32'h72);
        clk_en = 1'b0; wr = 1'b1; daddr = STDOUT; dout = 32'h73; tx_ready = 1'b1;
        repeat (5) step();
        daddr = HALT;
        repeat (5) step();
        wr = 1'b0;
        #2;
        check("cken_level", int'(level), 2);
        check("cken_count", int'(char_count), 0);
        check("cken_halt", int'(halt), 0);
        clk_en = 1'b1;
        repeat (3) step();

        // Reset in the middle of a drain
        tx_ready = 1'b0;
        write(STDOUT, 32'h81);
        write(STDOUT, 32'h82);
        write(HALT, 32'h0);
        #2;
        check("pre_rst_level", int'(level), 2);
        rstb = 1'b0;
        #1;
        check("midrst_valid", int'(tx_valid), 0);
        check("midrst_level", int'(level), 0);
        check("midrst_data", int'(tx_data), 0);
        step();
        rstb = 1'b1;
        step();
        #2;
        check("post_rst_empty", int'(level), 0);
        check("post_rst_run", int'(stall), 0);

        // Random traffic over several episodes
        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            for (int c = 0; c < 300; c++) begin
                int sel;
                sel      = $urandom_range(0, 63);
                clk_en   = ($urandom_range(0, 7) != 0);
                tx_ready = $urandom_range(0, 1);
                wr       = $urandom_range(0, 1);
                dout     = $urandom;
                daddr    = (sel == 0) ? HALT : (sel <= 8) ? 24'($urandom) : STDOUT;
                step();
            end
            wr = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
